uop_mem_responder: RTL and testbench
====================================

Name: uop_mem_responder

Overview:
- Memory-side responder for the uop execution stage.
- Accepts the stage's MAR write and memory request strobes and runs the access on the 8-bit external bus: one beat for a byte, two little-endian beats for a word.
- Holds the execution stage with a registered stop while the access is in flight.
- Returns read data, with its scheduler tag, for register write-back.

Parameters:
- ADDR_W, 16, address width of MAR and bus address.
- TIMEOUT, 255, max cycles waiting for bus_ack per beat before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge
- a_rst  in  1  asynchronous active-low reset
- mar_wr  in  1  load MAR from mar_in this cycle
- mar_in  in  ADDR_W  address from ALU result
- mem_rq  in  1  memory request strobe (already gated by stop upstream)
- mem_rq_cmd  in  1  1=write, 0=read
- mem_rq_width  in  1  1=16-bit word, 0=byte
- main_ex_mem  in  1  scheduler tag of the request
- wr_data  in  16  store data
- stop  out  1  registered stall to execution stage
- rd_valid  out  1  one-cycle pulse: rd_data valid
- rd_data  out  16  read result; byte reads zero-extended
- rd_main  out  1  tag of the completed read
- bus_err  out  1  one-cycle pulse on timeout abort
- mar  out  ADDR_W  current MAR contents
- bus_rq  out  1  external bus request, held until ack
- bus_we  out  1  external write enable
- bus_adr  out  ADDR_W  external byte address
- bus_dout  out  8  external write byte
- bus_din  in  8  external read byte
- bus_ack  in  1  beat complete; sampled on rising clk

Behaviour:
- Reset (a_rst low, async): state IDLE, mar=0, stop=0, rd_valid=0, rd_data=0, rd_main=0, bus_err=0, bus_rq=0, bus_we=0, bus_adr=0, bus_dout=0, timeout counter=0.
- MAR update: mar<=mar_in when mar_wr & ~stop. Effective request address = mar_wr ? mar_in : mar (same-uop bypass).
- States: IDLE, LO, HI, DONE.
- IDLE, mem_rq=1:
  - Latch cmd, width, tag, wr_data, effective address A.
  - Next cycle: stop=1, bus_rq=1, bus_adr=A, bus_we=cmd, bus_dout=wr_data[7:0]. Go to LO.
  - mem_rq while stop=1 is ignored (cannot occur legally).
- LO:
  - On bus_ack, reads capture bus_din into rd_data[7:0].
  - Byte access: go to DONE.
  - Word access: go to HI; bus_adr=A+1 mod 2^ADDR_W (0xFFFF wraps to 0x0000); bus_dout=wr_data[15:8].
  - bus_rq stays high between beats; bus_adr/bus_dout change only after the ack edge.
- HI: on bus_ack, reads capture bus_din into rd_data[15:8]; go to DONE.
- DONE (one cycle):
  - bus_rq=0, stop=0.
  - Reads: rd_valid=1, rd_main=latched tag; rd_data holds until the next read completes.
  - Writes: rd_valid stays 0.
  - Go to IDLE. A new mem_rq may be accepted in the cycle after DONE.
- Latency:
  - Byte access with bus_ack in the first bus cycle: stop high 2 cycles.
  - Word access with acks in the first bus cycle of each beat: stop high 3 cycles.
  - Each bus wait cycle adds one.
- Byte read: rd_data[15:8]=0.
- Timeout:
  - Counter resets at each beat start and increments while bus_rq & ~bus_ack.
  - Reaching TIMEOUT aborts: bus_rq=0, bus_err pulse, stop released, go to IDLE, rd_valid not asserted, rd_data unchanged.
- bus_ack in IDLE or DONE: ignored.
- Reset mid-access: everything returns to reset values immediately; the in-flight access is dropped with no rd_valid.

Test Plan:
- Byte read: mar_wr=1, mar_in=0x1234, mem_rq=1, cmd=0, width=0; bus_din=0xAB, ack on first cycle -> bus_adr=0x1234, stop high 2 cycles, rd_valid with rd_data=0x00AB.
- Word write with MAR set earlier to 0x2000, wr_data=0xBEEF, ack delayed 2 cycles per beat -> beats (0x2000,0xEF) then (0x2001,0xBE), bus_we=1, stop high 7 cycles, no rd_valid.
- Word read at 0xFFFF, bus_din 0x34 then 0x12, main_ex_mem=1 -> second bus_adr=0x0000, rd_data=0x1234, rd_main=1.
- Timeout with TIMEOUT=4 and bus_ack never asserted -> bus_err pulse after 4 wait cycles, stop falls, no rd_valid, next request accepted normally.
- a_rst low during HI of a word read -> all outputs zero immediately, no rd_valid after reset release.
- MAR hold: mar_wr=1 while stop=1 -> mar unchanged; back-to-back requests after DONE both complete correctly.

Source files
------------

// File: rtl/uop_mem_responder_if.sv
// External 8-bit memory bus between the uop memory responder and the memory system.
// Handshake: bus_rq is held high with stable bus_adr/bus_we/bus_dout until bus_ack is sampled on a rising clk; that edge completes the beat.
interface uop_bus_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              bus_rq;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_adr;
  logic [7:0]        bus_dout;
  logic [7:0]        bus_din;
  logic              bus_ack;

  modport master (
    output bus_rq, bus_we, bus_adr, bus_dout,
    input  bus_din, bus_ack
  );

  modport slave (
    input  bus_rq, bus_we, bus_adr, bus_dout,
    output bus_din, bus_ack
  );
endinterface

// File: rtl/uop_mem_responder.sv
// Memory-side responder for the uop execution stage: runs byte/word accesses as
// one or two little-endian beats on the 8-bit bus, stalls the stage, returns tagged read data.
module uop_mem_responder #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              a_rst,
  input  logic              mar_wr,
  input  logic [ADDR_W-1:0] mar_in,
  input  logic              mem_rq,
  input  logic              mem_rq_cmd,
  input  logic              mem_rq_width,
  input  logic              main_ex_mem,
  input  logic [15:0]       wr_data,
  output logic              stop,
  output logic              rd_valid,
  output logic [15:0]       rd_data,
  output logic              rd_main,
  output logic              bus_err,
  output logic [ADDR_W-1:0] mar,
  output logic [1:0]        state_dbg,
  uop_bus_if.master         bus
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic              stop_q, stop_d;
  logic              rd_valid_q, rd_valid_d;
  logic [15:0]       rd_data_q, rd_data_d;
  logic              rd_main_q, rd_main_d;
  logic              bus_err_q, bus_err_d;
  logic              bus_rq_q, bus_rq_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_adr_q, bus_adr_d;
  logic [7:0]        bus_dout_q, bus_dout_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wide_q, wide_d;
  logic              tag_q, tag_d;
  logic [7:0]        wd_hi_q, wd_hi_d;
  logic [7:0]        lo_q, lo_d;

  logic [ADDR_W-1:0] eff_adr;
  logic              to_hit;

  // A uop that writes MAR and requests memory in the same cycle uses the new address.
  assign eff_adr = mar_wr ? mar_in : mar_q;
  assign to_hit  = (TIMEOUT != 0) && (32'(cnt_q) == TIMEOUT - 32'd1);

  always_comb begin
    state_d    = state_q;
    mar_d      = mar_q;
    stop_d     = stop_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    rd_main_d  = rd_main_q;
    bus_err_d  = 1'b0;
    bus_rq_d   = bus_rq_q;
    bus_we_d   = bus_we_q;
    bus_adr_d  = bus_adr_q;
    bus_dout_d = bus_dout_q;
    cnt_d      = cnt_q;
    wide_d     = wide_q;
    tag_d      = tag_q;
    wd_hi_d    = wd_hi_q;
    lo_d       = lo_q;

    if (mar_wr && !stop_q) mar_d = mar_in;

    case (state_q)
      S_IDLE: begin
        if (mem_rq && !stop_q) begin
          state_d    = S_LO;
          stop_d     = 1'b1;
          bus_rq_d   = 1'b1;
          bus_we_d   = mem_rq_cmd;
          bus_adr_d  = eff_adr;
          bus_dout_d = wr_data[7:0];
          wd_hi_d    = wr_data[15:8];
          wide_d     = mem_rq_width;
          tag_d      = main_ex_mem;
          cnt_d      = '0;
        end
      end
      S_LO, S_HI: begin
        if (bus.bus_ack) begin
          cnt_d = '0;
          if (state_q == S_LO && wide_q) begin
            state_d    = S_HI;
            bus_adr_d  = bus_adr_q + ADDR_W'(1);
            bus_dout_d = wd_hi_q;
            lo_d       = bus.bus_din;
          end else begin
            state_d  = S_DONE;
            bus_rq_d = 1'b0;
            // rd_data is only replaced when a read fully completes, so an abort leaves it intact.
            if (!bus_we_q) begin
              rd_valid_d = 1'b1;
              rd_main_d  = tag_q;
              rd_data_d  = (state_q == S_HI) ? {bus.bus_din, lo_q} : {8'h00, bus.bus_din};
            end
          end
        end else if (to_hit) begin
          state_d   = S_IDLE;
          bus_rq_d  = 1'b0;
          stop_d    = 1'b0;
          bus_err_d = 1'b1;
          cnt_d     = '0;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        stop_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      state_q    <= S_IDLE;
      mar_q      <= '0;
      stop_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_main_q  <= 1'b0;
      bus_err_q  <= 1'b0;
      bus_rq_q   <= 1'b0;
      bus_we_q   <= 1'b0;
      bus_adr_q  <= '0;
      bus_dout_q <= '0;
      cnt_q      <= '0;
      wide_q     <= 1'b0;
      tag_q      <= 1'b0;
      wd_hi_q    <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      mar_q      <= mar_d;
      stop_q     <= stop_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_main_q  <= rd_main_d;
      bus_err_q  <= bus_err_d;
      bus_rq_q   <= bus_rq_d;
      bus_we_q   <= bus_we_d;
      bus_adr_q  <= bus_adr_d;
      bus_dout_q <= bus_dout_d;
      cnt_q      <= cnt_d;
      wide_q     <= wide_d;
      tag_q      <= tag_d;
      wd_hi_q    <= wd_hi_d;
      lo_q       <= lo_d;
    end
  end

  assign stop         = stop_q;
  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;
  assign rd_main      = rd_main_q;
  assign bus_err      = bus_err_q;
  assign mar          = mar_q;
  assign state_dbg    = state_q;
  assign bus.bus_rq   = bus_rq_q;
  assign bus.bus_we   = bus_we_q;
  assign bus.bus_adr  = bus_adr_q;
  assign bus.bus_dout = bus_dout_q;

endmodule

// File: tb/tb_uop_mem_responder.sv
// Directed bench for uop_mem_responder: byte/word reads and writes, address wrap,
// timeout abort, reset mid-access, MAR hold and back-to-back requests.
module tb_uop_mem_responder;

  logic        clk = 1'b0;
  logic        a_rst;
  logic        mar_wr;
  logic [15:0] mar_in;
  logic        mem_rq;
  logic        mem_rq_cmd;
  logic        mem_rq_width;
  logic        main_ex_mem;
  logic [15:0] wr_data;
  logic        stop;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        rd_main;
  logic        bus_err;
  logic [15:0] mar;
  logic [1:0]  state_dbg;

  int compared   = 0;
  int mismatched = 0;
  int stop_cyc   = 0;
  int rdv_cnt    = 0;

  uop_bus_if #(.ADDR_W(16)) bus_if ();

  uop_mem_responder #(.ADDR_W(16), .TIMEOUT(4)) dut (
    .clk          (clk),
    .a_rst        (a_rst),
    .mar_wr       (mar_wr),
    .mar_in       (mar_in),
    .mem_rq       (mem_rq),
    .mem_rq_cmd   (mem_rq_cmd),
    .mem_rq_width (mem_rq_width),
    .main_ex_mem  (main_ex_mem),
    .wr_data      (wr_data),
    .stop         (stop),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .rd_main      (rd_main),
    .bus_err      (bus_err),
    .mar          (mar),
    .state_dbg    (state_dbg),
    .bus          (bus_if)
  );

  always #5 clk = ~clk;

  // Advance one clock and sample just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (stop) stop_cyc++;
    if (rd_valid) rdv_cnt++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    a_rst = 1'b0; mar_wr = 1'b0; mar_in = '0; mem_rq = 1'b0; mem_rq_cmd = 1'b0;
    mem_rq_width = 1'b0; main_ex_mem = 1'b0; wr_data = '0;
    bus_if.bus_din = '0; bus_if.bus_ack = 1'b0;
    repeat (2) tick();
    chk("rst_stop",   32'(stop), 32'd0);
    chk("rst_rdv",    32'(rd_valid), 32'd0);
    chk("rst_rdata",  32'(rd_data), 32'd0);
    chk("rst_rmain",  32'(rd_main), 32'd0);
    chk("rst_err",    32'(bus_err), 32'd0);
    chk("rst_mar",    32'(mar), 32'd0);
    chk("rst_rq",     32'(bus_if.bus_rq), 32'd0);
    chk("rst_we",     32'(bus_if.bus_we), 32'd0);
    chk("rst_adr",    32'(bus_if.bus_adr), 32'd0);
    chk("rst_dout",   32'(bus_if.bus_dout), 32'd0);
    chk("rst_state",  32'(state_dbg), 32'd0);
    a_rst = 1'b1;
    tick();

    // Byte read with MAR bypass, ack in first bus cycle.
    mar_wr = 1'b1; mar_in = 16'h1234; mem_rq = 1'b1; mem_rq_cmd = 1'b0; mem_rq_width = 1'b0;
    main_ex_mem = 1'b0; stop_cyc = 0; rdv_cnt = 0;
    tick();
    mar_wr = 1'b0; mem_rq = 1'b0; mar_in = 16'h5555;
    chk("t1_adr",   32'(bus_if.bus_adr), 32'h1234);
    chk("t1_rq",    32'(bus_if.bus_rq), 32'd1);
    chk("t1_we",    32'(bus_if.bus_we), 32'd0);
    chk("t1_state", 32'(state_dbg), 32'd1);
    chk("t1_mar",   32'(mar), 32'h1234);
    bus_if.bus_din = 8'hAB; bus_if.bus_ack = 1'b1;
    tick();
    bus_if.bus_ack = 1'b0;
    chk("t1_rdv",   32'(rd_valid), 32'd1);
    chk("t1_rdata", 32'(rd_data), 32'h00AB);
    chk("t1_rmain", 32'(rd_main), 32'd0);
    chk("t1_rq_done", 32'(bus_if.bus_rq), 32'd0);
    tick();
    chk("t1_stop_cyc", 32'(stop_cyc), 32'd2);
    chk("t1_rdv_cnt",  32'(rdv_cnt), 32'd1);
    chk("t1_stop_end", 32'(stop), 32'd0);

    // Word write from previously loaded MAR, two wait cycles per beat.
    mar_wr = 1'b1; mar_in = 16'h2000;
    tick();
    mar_wr = 1'b0; mar_in = 16'h5555;
    chk("t2_mar", 32'(mar), 32'h2000);
    mem_rq = 1'b1; mem_rq_cmd = 1'b1; mem_rq_width = 1'b1; wr_data = 16'hBEEF;
    stop_cyc = 0; rdv_cnt = 0;
    tick();
    mem_rq = 1'b0; wr_data = '0;
    chk("t2_adr0",  32'(bus_if.bus_adr), 32'h2000);
    chk("t2_dout0", 32'(bus_if.bus_dout), 32'hEF);
    chk("t2_we",    32'(bus_if.bus_we), 32'd1);
    repeat (2) tick();
    chk("t2_adr0_hold", 32'(bus_if.bus_adr), 32'h2000);
    chk("t2_rq_hold",   32'(bus_if.bus_rq), 32'd1);
    bus_if.bus_ack = 1'b1;
    tick();
    bus_if.bus_ack = 1'b0;
    chk("t2_adr1",  32'(bus_if.bus_adr), 32'h2001);
    chk("t2_dout1", 32'(bus_if.bus_dout), 32'hBE);
    chk("t2_state_hi", 32'(state_dbg), 32'd2);
    chk("t2_rq_between", 32'(bus_if.bus_rq), 32'd1);
    repeat (2) tick();
    bus_if.bus_ack = 1'b1;
    tick();
    bus_if.bus_ack = 1'b0;
    chk("t2_rq_done",    32'(bus_if.bus_rq), 32'd0);
    chk("t2_state_done", 32'(state_dbg), 32'd3);
    tick();
    chk("t2_stop_cyc", 32'(stop_cyc), 32'd7);
    chk("t2_no_rdv",   32'(rdv_cnt), 32'd0);
    chk("t2_rdata",    32'(rd_data), 32'h00AB);

    // Word read at 0xFFFF: second beat wraps to 0x0000.
    mar_wr = 1'b1; mar_in = 16'hFFFF; mem_rq = 1'b1; mem_rq_cmd = 1'b0; mem_rq_width = 1'b1;
    main_ex_mem = 1'b1; stop_cyc = 0; rdv_cnt = 0;
    tick();
    mar_wr = 1'b0; mem_rq = 1'b0; main_ex_mem = 1'b0;
    chk("t3_adr0", 32'(bus_if.bus_adr), 32'hFFFF);
    bus_if.bus_din = 8'h34; bus_if.bus_ack = 1'b1;
    tick();
    chk("t3_adr1", 32'(bus_if.bus_adr), 32'h0000);
    chk("t3_state_hi", 32'(state_dbg), 32'd2);
    bus_if.bus_din = 8'h12;
    tick();
    bus_if.bus_ack = 1'b0;
    chk("t3_rdv",   32'(rd_valid), 32'd1);
    chk("t3_rdata", 32'(rd_data), 32'h1234);
    chk("t3_rmain", 32'(rd_main), 32'd1);
    tick();
    chk("t3_stop_cyc", 32'(stop_cyc), 32'd3);
    chk("t3_rdv_cnt",  32'(rdv_cnt), 32'd1);

    // Timeout: no ack, TIMEOUT=4 aborts after four wait cycles.
    mar_wr = 1'b1; mar_in = 16'h0055; mem_rq = 1'b1; mem_rq_cmd = 1'b0; mem_rq_width = 1'b0;
    stop_cyc = 0; rdv_cnt = 0;
    tick();
    mar_wr = 1'b0; mem_rq = 1'b0;
    repeat (3) tick();
    chk("t4_rq_wait",  32'(bus_if.bus_rq), 32'd1);
    chk("t4_err_wait", 32'(bus_err), 32'd0);
    tick();
    chk("t4_err",   32'(bus_err), 32'd1);
    chk("t4_stop",  32'(stop), 32'd0);
    chk("t4_rq",    32'(bus_if.bus_rq), 32'd0);
    chk("t4_state", 32'(state_dbg), 32'd0);
    tick();
    chk("t4_err_pulse", 32'(bus_err), 32'd0);
    chk("t4_no_rdv",    32'(rdv_cnt), 32'd0);
    chk("t4_rdata",     32'(rd_data), 32'h1234);
    chk("t4_stop_cyc",  32'(stop_cyc), 32'd4);
    mar_wr = 1'b1; mar_in = 16'h0010; mem_rq = 1'b1; mem_rq_cmd = 1'b1; mem_rq_width = 1'b0;
    wr_data = 16'h005A; stop_cyc = 0;
    tick();
    mar_wr = 1'b0; mem_rq = 1'b0; wr_data = '0;
    chk("t4b_adr",  32'(bus_if.bus_adr), 32'h0010);
    chk("t4b_dout", 32'(bus_if.bus_dout), 32'h5A);
    bus_if.bus_ack = 1'b1;
    tick();
    bus_if.bus_ack = 1'b0;
    tick();
    chk("t4b_stop_cyc", 32'(stop_cyc), 32'd2);
    chk("t4b_no_rdv",   32'(rdv_cnt), 32'd0);

    // Reset asserted during the high beat of a word read.
    mar_wr = 1'b1; mar_in = 16'h3000; mem_rq = 1'b1; mem_rq_cmd = 1'b0; mem_rq_width = 1'b1;
    main_ex_mem = 1'b1;
    tick();
    mar_wr = 1'b0; mem_rq = 1'b0; main_ex_mem = 1'b0;
    bus_if.bus_din = 8'h77; bus_if.bus_ack = 1'b1;
    tick();
    bus_if.bus_ack = 1'b0;
    chk("t5_state_hi", 32'(state_dbg), 32'd2);
    a_rst = 1'b0;
    #1;
    chk("t5_stop",  32'(stop), 32'd0);
    chk("t5_rq",    32'(bus_if.bus_rq), 32'd0);
    chk("t5_adr",   32'(bus_if.bus_adr), 32'd0);
    chk("t5_dout",  32'(bus_if.bus_dout), 32'd0);
    chk("t5_mar",   32'(mar), 32'd0);
    chk("t5_rdata", 32'(rd_data), 32'd0);
    chk("t5_rmain", 32'(rd_main), 32'd0);
    chk("t5_state", 32'(state_dbg), 32'd0);
    tick();
    a_rst = 1'b1; rdv_cnt = 0;
    bus_if.bus_din = 8'h99; bus_if.bus_ack = 1'b1;
    repeat (3) tick();
    bus_if.bus_ack = 1'b0;
    chk("t5_no_rdv",     32'(rdv_cnt), 32'd0);
    chk("t5_stop_after", 32'(stop), 32'd0);
    chk("t5_rdata_after", 32'(rd_data), 32'd0);

    // MAR held while stalled, then a back-to-back request using the stored MAR.
    mar_wr = 1'b1; mar_in = 16'h4000; mem_rq = 1'b1; mem_rq_cmd = 1'b0; mem_rq_width = 1'b0;
    stop_cyc = 0; rdv_cnt = 0;
    tick();
    mem_rq = 1'b0; mar_in = 16'h9999;
    tick();
    chk("t6_mar_hold", 32'(mar), 32'h4000);
    bus_if.bus_din = 8'h11; bus_if.bus_ack = 1'b1;
    tick();
    bus_if.bus_ack = 1'b0;
    chk("t6_rdv1",   32'(rd_valid), 32'd1);
    chk("t6_rdata1", 32'(rd_data), 32'h0011);
    chk("t6_mar_done", 32'(mar), 32'h4000);
    mar_wr = 1'b0;
    tick();
    mem_rq = 1'b1;
    tick();
    mem_rq = 1'b0;
    chk("t6_adr2", 32'(bus_if.bus_adr), 32'h4000);
    bus_if.bus_din = 8'h22; bus_if.bus_ack = 1'b1;
    tick();
    bus_if.bus_ack = 1'b0;
    chk("t6_rdata2", 32'(rd_data), 32'h0022);
    tick();
    chk("t6_rdv_cnt", 32'(rdv_cnt), 32'd2);

    // Stray ack while idle.
    stop_cyc = 0; rdv_cnt = 0; bus_if.bus_ack = 1'b1;
    repeat (2) tick();
    bus_if.bus_ack = 1'b0;
    chk("t7_stop_cyc", 32'(stop_cyc), 32'd0);
    chk("t7_no_rdv",   32'(rdv_cnt), 32'd0);
    chk("t7_state",    32'(state_dbg), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
